// File: rtl/dmem_pkg.sv
// Shared size encodings, responder FSM states and the load-extension helper.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input logic [1:0]  size,
                                           input logic        sgn);
        logic [31:0] r;
        r = raw;
        if (size == SZ_BYTE) begin
            r = {{24{sgn & raw[7]}}, raw[7:0]};
        end else if (size == SZ_HALF) begin
            r = {{16{sgn & raw[15]}}, raw[15:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian byte-lane steering for stores, lane extraction and extension for loads.
// DMEM_ALIGN_CHECK_EN: flag misaligned halfword/word accesses instead of masking low address bits.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [1:0]  off;
    logic [31:0] raw;

    always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
        off        = off_i;
        misalign_o = ((size_i == SZ_HALF) && off_i[0]) ||
                     ((size_i == SZ_WORD) && (off_i != 2'b00));
`else
        misalign_o = 1'b0;
        case (size_i)
            SZ_HALF: off = {off_i[1], 1'b0};
            SZ_WORD: off = 2'b00;
            default: off = off_i;
        endcase
`endif
    end

    // Byte offset 0 is the most significant lane (bits 31:24).
    always_comb begin
        be_o    = '0;
        wlane_o = '0;
        raw     = '0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b1000 >> off;
                wlane_o = {4{wdata_i[7:0]}};
                raw     = (rword_i >> (5'd24 - {off, 3'b000})) & 32'h0000_00FF;
            end
            SZ_HALF: begin
                be_o    = 4'b1100 >> off;
                wlane_o = {2{wdata_i[15:0]}};
                raw     = (rword_i >> (5'd16 - {off, 3'b000})) & 32'h0000_FFFF;
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wlane_o = wdata_i;
                raw     = rword_i;
            end
            default: begin
                be_o    = '0;
                wlane_o = '0;
                raw     = '0;
            end
        endcase
        rdata_o = extend(raw, size_i, signed_i);
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states, big-endian word store.
// Alignment policy follows DMEM_ALIGN_CHECK_EN (resolved inside dmem_lane_align).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

    state_t      state_q;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        ready_q, valid_q, err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          acc_we, acc_signed;
    logic [1:0]    acc_size;
    logic [31:0]   acc_addr, acc_wdata;
    logic [AW-1:0] acc_idx;
    logic          in_range, misalign, acc_err, do_access, wr_en;
    logic [31:0]   rword, lane_rdata, acc_rdata, wlane;
    logic [3:0]    be;

    // With WAIT_CYCLES = 0 the access is made on the acceptance edge straight from the request inputs.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we     = req_we;
            acc_size   = req_size;
            acc_signed = req_signed;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
        end else begin
            acc_we     = we_q;
            acc_size   = size_q;
            acc_signed = signed_q;
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
        end
    end

    assign acc_idx   = acc_addr[AW+1:2];
    assign in_range  = acc_addr < LIMIT;
    assign rword     = in_range ? mem_q[acc_idx] : '0;
    assign acc_err   = (acc_size == 2'b11) || !in_range || misalign;
    assign acc_rdata = (acc_err || acc_we) ? '0 : lane_rdata;
    assign do_access = ((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                       ((state_q == WAIT) && (cnt_q == 4'd1));
    assign wr_en     = do_access && acc_we && !acc_err && !reset;
    assign cnt_d     = cnt_q - 4'd1;

    dmem_lane_align u_lane (
        .size_i     (acc_size),
        .off_i      (acc_addr[1:0]),
        .signed_i   (acc_signed),
        .wdata_i    (acc_wdata),
        .rword_i    (rword),
        .be_o       (be),
        .wlane_o    (wlane),
        .rdata_o    (lane_rdata),
        .misalign_o (misalign)
    );

    // Store contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem_q[acc_idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        ready_q  <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                            rdata_q <= acc_rdata;
                            err_q   <= acc_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (do_access) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                        rdata_q <= acc_rdata;
                        err_q   <= acc_err;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES = 2 and 0) checked against a byte-array model.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v2 = 1'b0, v0 = 1'b0, rr2 = 1'b0, rr0 = 1'b0;
    logic        req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rdy2, rv2, re2, rdy0, rv0, re0;
    logic [31:0] rd2, rd0;

    int total = 0;
    int bad   = 0;

    // Reference store: one byte array per instance; index 0 = WAIT_CYCLES 2, index 1 = WAIT_CYCLES 0.
    logic [7:0] mb [2][1024];

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(rst), .req_valid(v2), .req_ready(rdy2), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv2), .resp_ready(rr2), .resp_rdata(rd2), .resp_err(re2)
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_ready(rr0), .resp_rdata(rd0), .resp_err(re0)
    );

    task automatic model(input bit d, input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
        int unsigned n;
        logic [31:0] a, v, lim;
        lim = d ? 32'd256 : 32'd1024;
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        a   = addr;
        err = 1'b0;
        rd  = '0;
        if (sz == 2'b11) err = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
        if (addr % n != 0) err = 1'b1;
`else
        a = addr - addr % n;
`endif
        if (a >= lim) err = 1'b1;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < int'(n); i++) mb[d][a + i] = 8'(wd >> (8 * (int'(n) - 1 - i)));
            end else begin
                v = '0;
                for (int i = 0; i < int'(n); i++) v = (v << 8) | 32'(mb[d][a + i]);
                if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endtask

    // Drives one transaction; lat counts cycles from the request cycle to the first cycle with resp_valid.
    task automatic txn(input bit d, input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input int hold,
                       output logic [31:0] o_rd, output logic o_err, output int lat,
                       output bit stable, output bit rdy_low,
                       output logic [31:0] e_rd, output logic e_err);
        bit got;
        model(d, we, sz, sgn, addr, wd, e_rd, e_err);
        @(negedge clk);
        req_we = we; req_size = sz; req_signed = sgn; req_addr = addr; req_wdata = wd;
        if (d) v0 = 1'b1; else v2 = 1'b1;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                v0 = 1'b0; v2 = 1'b0;
                req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
            @(negedge clk);
            lat++;
            got = d ? rv0 : rv2;
        end
        if (!got) lat = 99;
        o_rd    = d ? rd0 : rd2;
        o_err   = d ? re0 : re2;
        stable  = 1'b1;
        rdy_low = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if ((d ? rv0 : rv2) !== 1'b1 || (d ? rd0 : rd2) !== o_rd || (d ? re0 : re2) !== o_err) stable = 1'b0;
            if ((d ? rdy0 : rdy2) !== 1'b0) rdy_low = 1'b0;
        end
        if (d) rr0 = 1'b1; else rr2 = 1'b1;
        @(posedge clk); #1;
        rr0 = 1'b0; rr2 = 1'b0;
    endtask

    logic [31:0] ord, erd;
    logic        oerr, eerr;
    int          lat;
    bit          stb, rlow;

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (rdy2 !== 1'b1 || rv2 !== 1'b0 || rd2 !== 32'h0 || re2 !== 1'b0) begin
            bad++; $display("FAIL reset_outs2 got ready=%b valid=%b rdata=%h err=%b exp 1 0 0 0", rdy2, rv2, rd2, re2); end
        total++; if (rdy0 !== 1'b1 || rv0 !== 1'b0 || rd0 !== 32'h0 || re0 !== 1'b0) begin
            bad++; $display("FAIL reset_outs0 got ready=%b valid=%b rdata=%h err=%b exp 1 0 0 0", rdy0, rv0, rd0, re0); end
        rst = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; v2 = 1'b1;
        @(posedge clk); #1; v2 = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        total++; if (rdy2 !== 1'b1 || rv2 !== 1'b0) begin
            bad++; $display("FAIL midreset got ready=%b valid=%b exp ready=1 valid=0", rdy2, rv2); end
        rst = 1'b0;
        txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (ord !== 32'h0 || oerr !== 1'b0) begin
            bad++; $display("FAIL midreset_load got %h/%b exp 00000000/0", ord, oerr); end
    endtask

    task automatic test_word_store;
        txn(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (ord !== 32'h0 || oerr !== 1'b0 || lat != 3) begin
            bad++; $display("FAIL word_store got rdata=%h err=%b lat=%0d exp 00000000 0 3", ord, oerr, lat); end
        txn(0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (ord !== 32'h11 || oerr !== 1'b0) begin
            bad++; $display("FAIL byte_ld_20 got %h exp 00000011", ord); end
        total++; if (lat != 3) begin
            bad++; $display("FAIL latency_w2 got %0d exp 3", lat); end
        txn(0, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (ord !== 32'h44 || oerr !== 1'b0) begin
            bad++; $display("FAIL byte_ld_23 got %h exp 00000044", ord); end
    endtask

    task automatic test_sign_ext;
        txn(0, 1'b1, 2'b01, 1'b0, 32'h40, 32'hABCD80F0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        txn(0, 1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (ord !== 32'hFFFF80F0) begin bad++; $display("FAIL half_signed got %h exp FFFF80F0", ord); end
        txn(0, 1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (ord !== 32'h000080F0) begin bad++; $display("FAIL half_unsigned got %h exp 000080F0", ord); end
        txn(0, 1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (ord !== 32'hFFFFFFF0) begin bad++; $display("FAIL byte_signed got %h exp FFFFFFF0", ord); end
    endtask

    task automatic test_misalign;
        txn(0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D, 0, ord, oerr, lat, stb, rlow, erd, eerr);
`ifdef DMEM_ALIGN_CHECK_EN
        total++; if (oerr !== 1'b1) begin bad++; $display("FAIL misalign_err got %b exp 1", oerr); end
        txn(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (ord !== 32'h11223344) begin bad++; $display("FAIL misalign_nowrite got %h exp 11223344", ord); end
`else
        total++; if (oerr !== 1'b0) begin bad++; $display("FAIL misalign_noerr got %b exp 0", oerr); end
        txn(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (ord !== 32'hCAFEF00D) begin bad++; $display("FAIL misalign_masked got %h exp CAFEF00D", ord); end
`endif
    endtask

    task automatic test_errors;
        txn(0, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (oerr !== 1'b1 || ord !== 32'h0) begin bad++; $display("FAIL range_err got %h/%b exp 00000000/1", ord, oerr); end
        txn(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (oerr !== 1'b1 || ord !== 32'h0) begin bad++; $display("FAIL size11_err got %h/%b exp 00000000/1", ord, oerr); end
        txn(0, 1'b1, 2'b11, 1'b0, 32'h30, 32'h55667788, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (ord !== 32'h0) begin bad++; $display("FAIL size11_nowrite got %h exp 00000000", ord); end
    endtask

    task automatic test_backpressure;
        txn(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5, ord, oerr, lat, stb, rlow, erd, eerr);
        total++; if (!stb || !rlow) begin bad++; $display("FAIL backpressure got stable=%b ready_low=%b exp 1 1", stb, rlow); end
        total++; if (ord !== erd || oerr !== eerr) begin bad++; $display("FAIL backpressure_data got %h/%b exp %h/%b", ord, oerr, erd, eerr); end
    endtask

    task automatic test_random;
        logic we, sgn; logic [1:0] sz; logic [31:0] addr, wd; int hold;
        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom); sgn = 1'($urandom); sz = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 7) == 0) ? 32'(1024 + $urandom_range(0, 8)) : 32'($urandom_range(0, 63));
            wd = $urandom; hold = $urandom_range(0, 2);
            txn(0, we, sz, sgn, addr, wd, hold, ord, oerr, lat, stb, rlow, erd, eerr);
            total++; if (ord !== erd || oerr !== eerr) begin
                bad++; $display("FAIL rand_w2 k=%0d we=%b sz=%b a=%h got %h/%b exp %h/%b", k, we, sz, addr, ord, oerr, erd, eerr); end
            total++; if (lat != 3) begin bad++; $display("FAIL rand_w2_lat k=%0d got %0d exp 3", k, lat); end
            if (hold > 0) begin
                total++; if (!stb || !rlow) begin bad++; $display("FAIL rand_w2_hold k=%0d got %b%b exp 11", k, stb, rlow); end
            end
        end
    endtask

    task automatic test_wait0;
        logic we, sgn; logic [1:0] sz; logic [31:0] addr, wd;
        for (int k = 0; k < 20; k++) begin
            we = (k < 8) ? 1'b1 : 1'($urandom); sgn = 1'($urandom); sz = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 270)); wd = $urandom;
            txn(1, we, sz, sgn, addr, wd, 0, ord, oerr, lat, stb, rlow, erd, eerr);
            total++; if (ord !== erd || oerr !== eerr) begin
                bad++; $display("FAIL rand_w0 k=%0d we=%b sz=%b a=%h got %h/%b exp %h/%b", k, we, sz, addr, ord, oerr, erd, eerr); end
            total++; if (lat != 1) begin bad++; $display("FAIL latency_w0 k=%0d got %0d exp 1", k, lat); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [6];
        logic [31:0] er;
        logic        ee;
        int          nresp;
        for (int i = 0; i < 6; i++) a[i] = 32'($urandom_range(0, 63)) << 2;
        rr0 = 1'b1;
        nresp = 0;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = a[0]; v0 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                model(1, 1'b0, 2'b10, 1'b0, a[k/2], 32'h0, er, ee);
                if (rv0 === 1'b1) nresp++;
                total++; if (rv0 !== 1'b1 || rdy0 !== 1'b0 || rd0 !== er || re0 !== ee) begin
                    bad++; $display("FAIL b2b_resp k=%0d got v=%b r=%b d=%h e=%b exp 1 0 %h %b", k, rv0, rdy0, rd0, re0, er, ee); end
            end else begin
                total++; if (rv0 !== 1'b0 || rdy0 !== 1'b1) begin
                    bad++; $display("FAIL b2b_idle k=%0d got v=%b r=%b exp 0 1", k, rv0, rdy0); end
                if (k / 2 + 1 < 6) req_addr = a[k/2 + 1]; else v0 = 1'b0;
            end
        end
        rr0 = 1'b0;
        total++; if (nresp != 6) begin bad++; $display("FAIL b2b_count got %0d exp 6", nresp); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 1024; i++) mb[d][i] = 8'h00;
        test_reset();
        test_word_store();
        test_sign_ext();
        test_misalign();
        test_errors();
        test_backpressure();
        test_random();
        test_wait0();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
